// File: rtl/rtc_bus_sequencer_pkg.sv
// rtl/rtc_bus_sequencer_pkg.sv - shared encodings and constants for the RTC bus sequencer
package rtc_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A_SET = 3'd1,
    ST_A_STB = 3'd2,
    ST_A_HLD = 3'd3,
    ST_D_SET = 3'd4,
    ST_D_STB = 3'd5,
    ST_D_HLD = 3'd6,
    ST_GAP   = 3'd7
  } state_t;

  localparam int RQ_INIT = 0;
  localparam int RQ_WR   = 1;
  localparam int RQ_RD   = 2;

  localparam logic [7:0] CMD_XFER_0      = 8'hF0;
  localparam logic [7:0] CMD_XFER_1      = 8'hF1;
  localparam logic [7:0] CMD_XFER_2      = 8'hF2;
  localparam logic [7:0] ADDR_DATE_DAY   = 8'h24;
  localparam logic [7:0] ADDR_DATE_MONTH = 8'h25;
  localparam logic [7:0] ADDR_DATE_YEAR  = 8'h26;

  // Strict priority: init beats write beats read.
  function automatic logic [2:0] pick_winner(input logic [2:0] req);
    logic [2:0] w;
    w = 3'b000;
    if (req[RQ_INIT])    w[RQ_INIT] = 1'b1;
    else if (req[RQ_WR]) w[RQ_WR]   = 1'b1;
    else if (req[RQ_RD]) w[RQ_RD]   = 1'b1;
    return w;
  endfunction

  function automatic logic [1:0] onehot_index(input logic [2:0] oh);
    if (oh[RQ_RD]) return 2'd2;
    if (oh[RQ_WR]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// rtl/rtc_refresh_timer.sv - free-running wrap counter producing a one-cycle periodic tick
module rtc_refresh_timer #(
  parameter int REFRESH_CYC = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - arbitrates three requesters onto the multiplexed RTC bus
module rtc_bus_sequencer
  import rtc_bus_sequencer_pkg::*;
#(
  parameter int PH_CYC      = 10,
  parameter int REFRESH_CYC = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [2:0]  op_wr,
  input  logic [23:0] addr_bus,
  input  logic [23:0] wdata_bus,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        refresh_tick,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        a_d
);

  localparam int PW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PH_CYC - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] ph_cnt_q, ph_cnt_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          op_wr_q, op_wr_d;
  logic          cap;
  logic [2:0]    cap_sel;
  logic [2:0]    winner;
  logic          ph_last;

  assign ph_last = (ph_cnt_q == PH_LAST);
  assign winner  = pick_winner(req);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cap     = 1'b0;
    cap_sel = gnt_q;
    case (state_q)
      ST_IDLE: begin
        // A held grant (locked owner went idle) excludes everyone else.
        if ((lock & gnt_q) != 3'b000) begin
          if ((req & gnt_q) != 3'b000) begin
            state_d = ST_A_SET;
            cap     = 1'b1;
          end
        end else begin
          gnt_d = winner;
          if (winner != 3'b000) begin
            state_d = ST_A_SET;
            cap     = 1'b1;
            cap_sel = winner;
          end
        end
      end
      ST_A_SET: if (ph_last) state_d = ST_A_STB;
      ST_A_STB: if (ph_last) state_d = ST_A_HLD;
      ST_A_HLD: if (ph_last) state_d = ST_D_SET;
      ST_D_SET: if (ph_last) state_d = ST_D_STB;
      ST_D_STB: if (ph_last) state_d = ST_D_HLD;
      ST_D_HLD: if (ph_last) state_d = ST_GAP;
      ST_GAP: begin
        if ((lock & gnt_q) != 3'b000) begin
          if ((req & gnt_q) != 3'b000) begin
            state_d = ST_A_SET;
            cap     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gnt_d   = 3'b000;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    if (cap) begin
      case (onehot_index(cap_sel))
        2'd0: begin
          addr_d  = addr_bus[7:0];
          wdata_d = wdata_bus[7:0];
          op_wr_d = op_wr[0];
        end
        2'd1: begin
          addr_d  = addr_bus[15:8];
          wdata_d = wdata_bus[15:8];
          op_wr_d = op_wr[1];
        end
        default: begin
          addr_d  = addr_bus[23:16];
          wdata_d = wdata_bus[23:16];
          op_wr_d = op_wr[2];
        end
      endcase
    end

    rdata_d = rdata_q;
    if (state_q == ST_D_STB && ph_last && !op_wr_q) rdata_d = ad_in;

    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_GAP) ph_cnt_d = '0;
    else                                                               ph_cnt_d = ph_cnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ph_cnt_q <= '0;
      gnt_q    <= 3'b000;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      op_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      op_wr_q  <= op_wr_d;
    end
  end

  // Strobes decode straight from the state register so an async reset releases the bus at once.
  always_comb begin
    ad_out = 8'h00;
    ad_oe  = 1'b0;
    a_d    = 1'b1;
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    case (state_q)
      ST_A_SET, ST_A_STB, ST_A_HLD: begin
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
        if (state_q == ST_A_STB) begin
          cs_n = 1'b0;
          wr_n = 1'b0;
        end
      end
      ST_D_SET, ST_D_STB, ST_D_HLD: begin
        if (op_wr_q) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
        if (state_q == ST_D_STB) begin
          cs_n = 1'b0;
          if (op_wr_q) wr_n = 1'b0;
          else         rd_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign gnt   = gnt_q;
  assign ack   = (state_q == ST_GAP) ? gnt_q : 3'b000;
  assign busy  = (state_q != ST_IDLE);
  assign rdata = rdata_q;

  rtc_refresh_timer #(
    .REFRESH_CYC(REFRESH_CYC)
  ) u_refresh_timer (
    .clk  (clk),
    .reset(reset),
    .tick (refresh_tick)
  );

endmodule
